// File: rtl/kmeans_mem_sched.sv
// Point-memory sequencer for the k-means engine: loads a data set into the
// single-port SRAM, replays it once per pass and handshakes centroid updates.
module kmeans_mem_sched #(
    parameter int ADDR_W   = 12,
    parameter int DATA_W   = 16,
    parameter int DEPTH    = 4096,
    parameter int RD_LAT   = 2,
    parameter int MAX_ITER = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    output logic              load_ready,
    output logic [ADDR_W-1:0] mem_a,
    output logic [DATA_W-1:0] mem_di,
    output logic              mem_web,
    input  logic [DATA_W-1:0] mem_do,
    output logic              pt_valid,
    output logic [DATA_W-1:0] pt_data,
    output logic              pt_last,
    output logic              update_req,
    input  logic              update_ack,
    input  logic              converged,
    output logic [7:0]        iter_cnt,
    output logic              busy,
    output logic              done,
    output logic              timeout,
    output logic [2:0]        dbg_state
);

    // Handshake: a load beat transfers on a rising edge where load_valid and
    // load_ready are both 1; update_ack is honoured only while update_req is 1.
    typedef enum logic [2:0] {IDLE, LOAD, SCAN, DRAIN, UPDATE, DONE} state_t;

    localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(DEPTH - 1);
    localparam logic [7:0]        LAST_IT = 8'(MAX_ITER - 1);

    state_t            state;
    logic [ADDR_W-1:0] wr_cnt;
    logic [ADDR_W-1:0] rd_addr;
    logic [RD_LAT-1:0] tok_v;
    logic [RD_LAT-1:0] tok_l;
    logic              accept;
    logic              issue;
    logic              issue_last;

    assign accept     = load_valid && load_ready;
    assign issue      = (state == SCAN);
    assign issue_last = issue && (rd_addr == LAST_A);
    assign dbg_state  = state;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            wr_cnt     <= '0;
            rd_addr    <= '0;
            tok_v      <= '0;
            tok_l      <= '0;
            load_ready <= 1'b0;
            mem_a      <= '0;
            mem_di     <= '0;
            mem_web    <= 1'b1;
            pt_valid   <= 1'b0;
            pt_data    <= '0;
            pt_last    <= 1'b0;
            update_req <= 1'b0;
            iter_cnt   <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            mem_web <= 1'b1;
            done    <= 1'b0;

            // Tokens ride alongside the registered read address so pt_valid
            // lands exactly RD_LAT cycles after the address cycle.
            tok_v[0] <= issue;
            tok_l[0] <= issue_last;
            for (int i = 1; i < RD_LAT; i++) begin
                tok_v[i] <= tok_v[i-1];
                tok_l[i] <= tok_l[i-1];
            end
            pt_valid <= tok_v[RD_LAT-1];
            pt_last  <= tok_v[RD_LAT-1] && tok_l[RD_LAT-1];
            if (tok_v[RD_LAT-1]) pt_data <= mem_do;

            case (state)
                IDLE, LOAD: begin
                    if (state == IDLE) load_ready <= 1'b1;
                    if (accept) begin
                        mem_a   <= wr_cnt;
                        mem_di  <= load_data;
                        mem_web <= 1'b0;
                        if (state == IDLE) begin
                            iter_cnt <= '0;
                            timeout  <= 1'b0;
                            busy     <= 1'b1;
                        end
                        if (wr_cnt == LAST_A) begin
                            load_ready <= 1'b0;
                            wr_cnt     <= '0;
                            rd_addr    <= '0;
                            state      <= SCAN;
                        end else begin
                            wr_cnt <= wr_cnt + ADDR_W'(1);
                            state  <= LOAD;
                        end
                    end
                end
                SCAN: begin
                    mem_a <= rd_addr;
                    if (rd_addr == LAST_A) state <= DRAIN;
                    else rd_addr <= rd_addr + ADDR_W'(1);
                end
                DRAIN: begin
                    if (pt_valid && pt_last) begin
                        update_req <= 1'b1;
                        state      <= UPDATE;
                    end
                end
                UPDATE: begin
                    if (update_ack) begin
                        update_req <= 1'b0;
                        iter_cnt   <= iter_cnt + 8'd1;
                        if (converged) begin
                            state   <= DONE;
                            done    <= 1'b1;
                            timeout <= 1'b0;
                        end else if (iter_cnt == LAST_IT) begin
                            state   <= DONE;
                            done    <= 1'b1;
                            timeout <= 1'b1;
                        end else begin
                            rd_addr <= '0;
                            state   <= SCAN;
                        end
                    end
                end
                DONE: begin
                    state      <= IDLE;
                    busy       <= 1'b0;
                    load_ready <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
